// File: rtl/ras_spill_ctrl.sv
// Return-address stack: on-chip circular buffer that spills oldest entries to memory and refills them.
// ra/ras_stall are combinational from registered state; one memory request in flight, held until mem_ack.
module ras_spill_ctrl #(
    parameter int DEPTH       = 16,
    parameter int SPILL_HI    = 12,
    parameter int FILL_LO     = 4,
    parameter int MEM_ENTRIES = 512,
    parameter int MEM_BASE    = 0,
    parameter int AW          = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic [13:0]   npc,
    input  logic          push,
    input  logic          pop,
    output logic [13:0]   ra,
    output logic          ras_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [13:0]   mem_wdata,
    input  logic [13:0]   mem_rdata,
    input  logic          mem_ack
);
    localparam int IW  = $clog2(DEPTH);
    localparam int CW  = IW + 1;
    localparam int MW  = $clog2(MEM_ENTRIES);
    localparam int MCW = MW + 1;

    localparam logic [CW-1:0]  C_DEPTH   = CW'(DEPTH);
    localparam logic [CW-1:0]  C_SPILL   = CW'(SPILL_HI);
    localparam logic [CW-1:0]  C_FILL    = CW'(FILL_LO);
    localparam logic [MCW-1:0] C_MENT    = MCW'(MEM_ENTRIES);
    localparam logic [AW-1:0]  C_BASE    = AW'(MEM_BASE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SPILL = 2'd1,
        S_FILL  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [13:0]     r_buf [DEPTH];
    logic [IW-1:0]   r_bot;
    logic [CW-1:0]   r_cnt;
    logic [MW-1:0]   r_mptr;
    logic [MCW-1:0]  r_mcnt;

    logic [IW-1:0]   w_top;
    logic [IW-1:0]   w_wr_idx;
    logic [IW-1:0]   w_fill_idx;
    logic            w_spill_ack;
    logic            w_fill_ack;
    logic            w_op_ok;
    logic            w_push_acc;
    logic            w_pop_acc;
    logic [CW-1:0]   w_cnt_nxt;

    assign w_top       = r_bot + r_cnt[IW-1:0] - IW'(1);
    assign w_wr_idx    = r_bot + r_cnt[IW-1:0];
    assign w_fill_idx  = r_bot - IW'(1);
    assign w_spill_ack = (r_state == S_SPILL) && mem_ack;
    assign w_fill_ack  = (r_state == S_FILL) && mem_ack;

    // The last free slot is kept for an outstanding fill; the spilled bottom entry must not be popped.
    assign ras_stall = (push && (r_cnt == C_DEPTH))
                    || (push && (r_state == S_FILL) && (r_cnt >= C_DEPTH - CW'(1)))
                    || (pop && (r_state == S_SPILL) && (r_cnt <= CW'(1)))
                    || (pop && (r_cnt == '0) && (r_mcnt != '0));

    assign w_op_ok    = !stall && !ras_stall;
    assign w_push_acc = w_op_ok && push;
    assign w_pop_acc  = w_op_ok && pop && !push && (r_cnt != '0);

    assign w_cnt_nxt = r_cnt + CW'(w_push_acc) + CW'(w_fill_ack)
                     - CW'(w_pop_acc) - CW'(w_spill_ack);

    assign ra = (r_cnt == '0) ? 14'd0 : r_buf[w_top];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_cnt >= C_SPILL) begin
                    w_state_nxt = S_SPILL;
                end else if ((r_cnt <= C_FILL) && (r_mcnt != '0)) begin
                    w_state_nxt = S_FILL;
                end
            end
            S_SPILL: if (mem_ack) w_state_nxt = S_IDLE;
            S_FILL:  if (mem_ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = C_BASE;
        mem_wdata = 14'd0;
        case (r_state)
            S_SPILL: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = C_BASE + AW'(r_mptr);
                mem_wdata = r_buf[r_bot];
            end
            S_FILL: begin
                mem_req  = 1'b1;
                mem_addr = C_BASE + AW'(r_mptr - MW'(1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_bot  <= '0;
            r_mptr <= '0;
            r_mcnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_spill_ack) begin
                r_bot  <= r_bot + IW'(1);
                r_mptr <= r_mptr + MW'(1);
                // Once the spill area is full, the oldest memory entry is silently overwritten.
                if (r_mcnt != C_MENT) r_mcnt <= r_mcnt + MCW'(1);
            end else if (w_fill_ack) begin
                r_bot  <= w_fill_idx;
                r_mptr <= r_mptr - MW'(1);
                r_mcnt <= r_mcnt - MCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_acc) r_buf[w_wr_idx] <= npc;
        if (w_fill_ack) r_buf[w_fill_idx] <= mem_rdata;
    end

endmodule

// File: tb/tb_ras_spill_ctrl.sv
// Directed bench for ras_spill_ctrl: scoreboard queues for ra after accepted ops and for memory transactions.
module tb_ras_spill_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [13:0] npc;
    logic        push;
    logic        pop;
    logic [13:0] ra;
    logic        ras_stall;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [13:0] mem_wdata;
    logic [13:0] mem_rdata;
    logic        mem_ack;

    ras_spill_ctrl #(
        .DEPTH(16), .SPILL_HI(12), .FILL_LO(4),
        .MEM_ENTRIES(512), .MEM_BASE(256), .AW(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .npc(npc),
        .push(push), .pop(pop), .ra(ra), .ras_stall(ras_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [13:0] wdata;
    } mexp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          ra_q [$];
    mexp_t       mq [$];
    logic [13:0] mem_model [512];
    logic        ack_en;
    int          ack_dly;
    int          force_cnt;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_mem(input logic we, input int addr, input int wdata);
        mexp_t e;
        e.we    = we;
        e.addr  = 16'(addr);
        e.wdata = 14'(wdata);
        mq.push_back(e);
    endtask

    // Memory responder: acks ack_dly cycles after req, or once on demand via force_cnt.
    initial begin : responder
        int age;
        int seen;
        age = 0;
        seen = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
                age = 0;
            end else if (force_cnt != seen) begin
                seen = force_cnt;
                mem_ack = 1'b1;
            end else if (mem_req && ack_en) begin
                age++;
                if (age >= ack_dly) begin
                    mem_ack = 1'b1;
                    age = 0;
                    if (mem_we) mem_model[mem_addr[8:0]] = mem_wdata;
                    else        mem_rdata = mem_model[mem_addr[8:0]];
                end
            end else begin
                age = 0;
            end
        end
    end

    initial begin : mem_monitor
        mexp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && mem_req && mem_ack) begin
                if (mq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL mem_unexpected: got we=%0d addr=0x%0h expected no transaction", mem_we, mem_addr);
                end else begin
                    e = mq.pop_front();
                    chk("mem_we", int'(mem_we), int'(e.we));
                    chk("mem_addr", int'(mem_addr), int'(e.addr));
                    if (e.we) chk("mem_wdata", int'(mem_wdata), int'(e.wdata));
                end
            end
        end
    end

    initial begin : ra_monitor
        logic acc_prev;
        int   e;
        acc_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                acc_prev = 1'b0;
            end else begin
                if (acc_prev) begin
                    if (ra_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL ra_unexpected_accept: got ra=0x%0h expected op to be stalled", ra);
                    end else begin
                        e = ra_q.pop_front();
                        chk("ra_after_op", int'(ra), e);
                    end
                end
                acc_prev = (push || pop) && !stall && !ras_stall;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Called at posedge+1; holds the op until it is accepted.
    task automatic op(input logic p, input logic q, input int n, input int exp_ra);
        int k;
        push = p;
        pop  = q;
        npc  = 14'(n);
        ra_q.push_back(exp_ra);
        k = 0;
        @(negedge clk);
        while (ras_stall && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (ras_stall) chk("op_timeout", 1, 0);
        tick();
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic quiesce();
        int lows;
        int k;
        lows = 0;
        k = 0;
        while (lows < 3 && k < 200) begin
            @(negedge clk);
            lows = mem_req ? 0 : lows + 1;
            k++;
        end
        if (lows < 3) chk("quiesce_timeout", 1, 0);
        tick();
    endtask

    task automatic do_reset();
        push = 1'b0;
        pop  = 1'b0;
        stall = 1'b0;
        ack_en = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k;
        rst_n = 1'b0;
        stall = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        npc = '0;
        ack_en = 1'b0;
        ack_dly = 2;
        force_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", int'(mem_req), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 16'h0100);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_ra", int'(ra), 0);
        chk("rst_ras_stall", int'(ras_stall), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        tick();

        // Basic push/pop, stall, push+pop, underflow
        op(1, 0, 'h100, 'h100);
        op(1, 0, 'h101, 'h101);
        op(1, 0, 'h102, 'h102);
        stall = 1'b1; push = 1'b1; npc = 14'h3ff;
        tick();
        stall = 1'b0; push = 1'b0;
        @(negedge clk);
        chk("stall_ignores_push", int'(ra), 'h102);
        tick();
        op(0, 1, 0, 'h101);
        op(1, 1, 'h200, 'h200);
        op(0, 1, 0, 'h101);
        op(0, 1, 0, 'h100);
        op(0, 1, 0, 0);
        op(0, 1, 0, 0);
        op(1, 0, 'h300, 'h300);
        op(0, 1, 0, 0);
        quiesce();

        // Single spill at the high threshold
        do_reset();
        ack_en = 1'b1;
        exp_mem(1, 'h100, 'h10);
        for (int i = 0; i < 12; i++) op(1, 0, 'h10 + i, 'h10 + i);
        quiesce();
        @(negedge clk);
        chk("spill1_ra", int'(ra), 'h1b);
        tick();

        // Full buffer with no ack: push 17 stalls until the spill completes
        do_reset();
        for (int i = 0; i < 6; i++) exp_mem(1, 'h100 + i, 'h10 + i);
        for (int i = 0; i < 16; i++) op(1, 0, 'h10 + i, 'h10 + i);
        push = 1'b1; npc = 14'h20;
        @(negedge clk);
        chk("full_ras_stall", int'(ras_stall), 1);
        chk("full_ra", int'(ra), 'h1f);
        chk("full_mem_req", int'(mem_req), 1);
        ra_q.push_back('h20);
        ack_en = 1'b1;
        k = 0;
        while (ras_stall && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("full_unstall", int'(ras_stall), 0);
        tick();
        push = 1'b0;
        quiesce();
        @(negedge clk);
        chk("full_ra_after", int'(ra), 'h20);
        tick();

        // Three spills, then drain with fills returning in LIFO order
        do_reset();
        ack_en = 1'b1;
        exp_mem(1, 'h100, 'h10);
        exp_mem(1, 'h101, 'h11);
        exp_mem(1, 'h102, 'h12);
        exp_mem(0, 'h102, 0);
        exp_mem(0, 'h101, 0);
        exp_mem(0, 'h100, 0);
        for (int i = 0; i < 14; i++) op(1, 0, 'h10 + i, 'h10 + i);
        quiesce();
        for (int i = 1; i <= 14; i++) begin
            op(0, 1, 0, (i <= 13) ? ('h1d - i) : 0);
            quiesce();
        end

        // Empty buffer with one spilled entry: pop waits for the fill
        do_reset();
        ack_en = 1'b1;
        exp_mem(1, 'h100, 'h10);
        for (int i = 0; i < 12; i++) op(1, 0, 'h10 + i, 'h10 + i);
        quiesce();
        ack_en = 1'b0;
        exp_mem(0, 'h100, 0);
        for (int i = 1; i <= 11; i++) op(0, 1, 0, (i <= 10) ? ('h1b - i) : 0);
        pop = 1'b1;
        @(negedge clk);
        chk("pop_wait_stall", int'(ras_stall), 1);
        chk("pop_wait_ra", int'(ra), 0);
        chk("pop_wait_req", int'(mem_req), 1);
        chk("pop_wait_we", int'(mem_we), 0);
        ack_en = 1'b1;
        k = 0;
        while (ras_stall && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("pop_wait_unstall", int'(ras_stall), 0);
        chk("fill_ra", int'(ra), 'h10);
        ra_q.push_back(0);
        tick();
        pop = 1'b0;
        quiesce();

        // Reset during a pending spill, then a stray ack
        do_reset();
        for (int i = 0; i < 12; i++) op(1, 0, 'h10 + i, 'h10 + i);
        k = 0;
        @(negedge clk);
        while (!mem_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_req_seen", int'(mem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_req", int'(mem_req), 0);
        chk("rst_mid_ra", int'(ra), 0);
        chk("rst_mid_addr", int'(mem_addr), 16'h0100);
        tick();
        rst_n = 1'b1;
        force_cnt++;
        repeat (4) tick();
        @(negedge clk);
        chk("late_ack_req", int'(mem_req), 0);
        chk("late_ack_ra", int'(ra), 0);
        tick();
        op(1, 0, 'h55, 'h55);
        quiesce();
        op(0, 1, 0, 0);
        quiesce();
        @(negedge clk);
        chk("late_ack_idle", int'(mem_req), 0);

        chk("ra_q_empty", ra_q.size(), 0);
        chk("mem_q_empty", mq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ras_spill_ctrl.md
# ras_spill_ctrl

Return-address-stack controller for the VLIW front end. It wraps a small on-chip circular RAS buffer and services the fetch stage's call/return push/pop with the same semantics as the core RAS. It transparently spills the oldest entries to data memory when the buffer runs high, and refills them when it runs low, so call depth is bounded by memory rather than by on-chip entries. It sits between fetch (push/pop/ra) and the data-memory arbiter (req/ack port).

## Interface
Parameters:
- DEPTH, 16: on-chip entries (power of two, ≥ 8).
- SPILL_HI, 12: occupancy at or above which a spill starts.
- FILL_LO, 4: occupancy at or below which a fill starts (when memory holds entries).
- MEM_ENTRIES, 512: spill-area capacity (power of two).
- MEM_BASE, 0: word address of the spill area.
- AW, 16: memory address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  pipeline stall; push/pop ignored while high.
- npc  in  14  return address to push.
- push  in  1  call: push npc.
- pop  in  1  return: pop top.
- ra  out  14  current top of stack, combinational; 0 when the buffer is empty.
- ras_stall  out  1  combinational; fetch must hold push/pop and stall.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = spill write, 0 = fill read.
- mem_addr  out  AW  MEM_BASE + slot index.
- mem_wdata  out  14  spilled entry.
- mem_rdata  in  14  fill data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion pulse.

## Operation
- State: buffer[DEPTH], bot (oldest slot), cnt (0..DEPTH), mptr (next free memory slot, log2 MEM_ENTRIES bits, wraps), mcnt (0..MEM_ENTRIES, saturating). Top slot = bot+cnt-1 mod DEPTH.
- An accepted op is an op with ~stall & ~ras_stall.
  - Push: write npc to slot bot+cnt; cnt+1.
  - Pop: cnt-1.
  - push & pop together: push only, pop is ignored.
  - Pop at cnt=0 and mcnt=0 (underflow) is accepted and has no effect.
- FSM states: IDLE, SPILL, FILL.
  - IDLE→SPILL when cnt ≥ SPILL_HI. Spill takes precedence over fill.
  - IDLE→FILL when cnt ≤ FILL_LO and mcnt > 0.
  - SPILL: mem_req=1, mem_we=1, mem_addr=MEM_BASE+mptr, mem_wdata=buffer[bot]. On mem_ack: bot+1, cnt-1, mptr+1, mcnt+1 (saturates at MEM_ENTRIES; when saturated the oldest memory entry is overwritten and lost); go to IDLE.
  - FILL: mem_req=1, mem_we=0, mem_addr=MEM_BASE+(mptr-1). On mem_ack: buffer[bot-1]=mem_rdata, bot-1, cnt+1, mptr-1, mcnt-1; go to IDLE.
- ras_stall is asserted when any of these holds:
  - push & cnt=DEPTH;
  - push & state=FILL & cnt ≥ DEPTH-1 (one slot is reserved for the fill);
  - pop & state=SPILL & cnt ≤ 1 (protects the entry being spilled);
  - pop & cnt=0 & mcnt>0 (return waits for a fill).
- Same-cycle core op and mem_ack both apply: cnt_next = cnt + push_acc − pop_acc − spill_ack + fill_ack.
- mem_addr, mem_we and mem_wdata are stable while mem_req is high. mem_ack outside SPILL/FILL is ignored.

## Timing
- Reset (async assert, release synchronous to clk): state IDLE, cnt=0, bot=0, mptr=0, mcnt=0, mem_req=0, mem_we=0, mem_addr=MEM_BASE, mem_wdata=0, ra=0, ras_stall=0. Buffer contents are don't-care. Reset mid-transaction drops mem_req immediately; a late mem_ack is ignored.
- ra reflects an accepted push or pop in the cycle after the edge.
- mem_req rises the cycle after the threshold condition is registered; the minimum spill/fill turnaround is 2 cycles (req, ack, IDLE).
- A fill's data is visible on ra the cycle after mem_ack when cnt was 0.
- Wrap-around: bot and top indices wrap modulo DEPTH; mptr wraps modulo MEM_ENTRIES.

## Test plan
- Reset, then push 0x0100, 0x0101, 0x0102 → ra=0x0102; pop → ra=0x0101; push+pop in the same cycle with npc=0x0200 → ra=0x0200, cnt=3.
- 12 pushes (0x10..0x1B), with mem_ack returned 2 cycles after req → spill write to addr MEM_BASE+0 with wdata=0x10; cnt=11, mcnt=1, ra=0x1B.
- 16 pushes with mem_ack held low → push #17 sees ras_stall=1 and ra stays 0x1F; after ack, push #17 is accepted.
- Spill 3 entries (0x10, 0x11, 0x12), then pop down to cnt=4 → fill read at MEM_BASE+2; mem_rdata=0x12 is inserted at the bottom; draining all pops returns the addresses in LIFO order ending ..., 0x12, 0x11, 0x10.
- cnt=0, mcnt=1, pop → ras_stall=1 until mem_ack; the next cycle ra=the spilled value; the pop is then accepted.
- Assert rst_n low while mem_req=1 in SPILL → mem_req=0 the same cycle, cnt=0, ra=0; a mem_ack after release causes no state change.
